// File: rtl/lock_pkg.sv
// lock_pkg: shared types and constants for the lock's keypad path.
package lock_pkg;
  localparam int NUM_KEYS = 4;
  typedef logic [1:0] key_code_t;
  typedef enum logic {IDLE, HELD} entry_state_t;
endpackage

// File: rtl/key_debouncer.sv
// key_debouncer: two-flop synchroniser plus saturating-count debouncer for one active-low key.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic db
);
  localparam int W = $clog2(DEBOUNCE_CYCLES);
  logic s1, s2;
  logic [W-1:0] cnt;
  always_ff @(posedge clock)
    if (reset) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      cnt <= '0;
      db  <= 1'b0;
    end else begin
      s1 <= ~key_n;
      s2 <= s1;
      if (s2 == db) cnt <= '0;
      else if (cnt == W'(DEBOUNCE_CYCLES - 1)) begin
        db  <= ~db;
        cnt <= '0;
      end else cnt <= cnt + W'(1);
    end
endmodule

// File: rtl/keypad_entry.sv
// keypad_entry: debounced 4-key encoder producing one strobe per press; KEYPAD_AUTOREPEAT_EN adds hold-to-repeat strobes.
module keypad_entry
  import lock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic                input_value,
  output logic [1:0]          bits,
  output logic                multi_err,
  output logic                busy
);
  logic [NUM_KEYS-1:0] db;
  entry_state_t state;
  key_code_t idx;
  logic one_hot, rep_fire;
  if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
    $error("keypad_entry: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 2");
  end
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clock (clock),
      .reset (reset),
      .key_n (key_n[i]),
      .db    (db[i])
    );
  end
  assign busy    = |db;
  assign one_hot = $onehot(db);
  always_comb begin
    idx = '0;
    for (int k = 0; k < NUM_KEYS; k++) if (db[k]) idx = key_code_t'(k);
  end
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES);
  logic [RW-1:0] rcnt;
  logic rep_on, rep_run;
  // rep_on drops for good once the held set deviates from the single strobed key
  assign rep_run  = rep_on && db == (NUM_KEYS'(1) << bits);
  assign rep_fire = state == HELD && rep_run && rcnt == RW'(REPEAT_CYCLES - 1);
  always_ff @(posedge clock)
    if (reset) begin
      rcnt   <= '0;
      rep_on <= 1'b0;
    end else if (state == IDLE) begin
      rcnt   <= '0;
      rep_on <= one_hot;
    end else if (rep_run) rcnt <= rcnt == RW'(REPEAT_CYCLES - 1) ? '0 : rcnt + RW'(1);
    else begin
      rcnt   <= '0;
      rep_on <= 1'b0;
    end
`else
  assign rep_fire = 1'b0;
`endif
  always_ff @(posedge clock)
    if (reset) begin
      state       <= IDLE;
      bits        <= '0;
      input_value <= 1'b0;
      multi_err   <= 1'b0;
    end else begin
      input_value <= (state == IDLE && one_hot) || rep_fire;
      multi_err   <= state == IDLE && busy && !one_hot;
      if (state == IDLE && one_hot) bits <= idx;
      state <= busy ? HELD : IDLE;
    end
endmodule
